// File: rtl/seg7_scan_decoder.sv
// seg7_scan_decoder
//
// Purpose:
//   This block recovers four decimal digits from a scanned, multiplexed
//   7-segment display bus. A digit is captured once its segment pattern and
//   digit strobe have been steady for STABLE_CNT consecutive cycles. After all
//   four digits have been seen, they are presented together as one frame.
//
// Parameters:
//   STABLE_CNT   Number of consecutive identical cycles before a capture.
//                Range 1..15.
//
// Ports:
//   clk          Single clock. All state changes on its rising edge.
//   rst          Synchronous, active-high reset. Takes priority over
//                everything else.
//   segment      Segment lines a..g. bit6 = a, bit0 = g, 1 = lit.
//   digit_sel    One-hot, active-high digit strobe. bit0 = digit 0.
//   ready        Consumer ready.
//   bcd_out      Decoded digits. [3:0] = digit 0 ... [15:12] = digit 3.
//   digit_err    Per-digit flag. 1 = pattern not recognised (value 4'hF).
//   valid        A complete frame is presented on bcd_out / digit_err.
//   overrun      Sticky. A completed frame was dropped while the previous
//                frame was still waiting.
//   dbg_state_o  Current FSM state. 0 = COLLECT, 1 = PRESENT.
//
// Configuration macro:
//   SEG7_BLANK_EN  When defined, the all-off pattern 0000000 decodes to
//                  4'hB (blank) with err = 0. Otherwise it is an error
//                  (4'hF, err = 1).
//
// Handshake:
//   A frame transfers on every rising edge where valid = 1 and ready = 1.
//   While valid = 1 and ready = 0, bcd_out, digit_err and valid stay
//   unchanged. valid never drops without a transfer, except on reset.
//   ready has no effect while valid = 0.
//
// All outputs come straight from flops. There is no combinational path
// from any input to any output.

module seg7_scan_decoder #(
  parameter int unsigned STABLE_CNT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [6:0]  segment,
  input  logic [3:0]  digit_sel,
  input  logic        ready,
  output logic [15:0] bcd_out,
  output logic [3:0]  digit_err,
  output logic        valid,
  output logic        overrun,
  output logic        dbg_state_o
);

  localparam logic [3:0] STABLE_W = 4'(STABLE_CNT);

  typedef enum logic {
    ST_COLLECT = 1'b0,
    ST_PRESENT = 1'b1
  } state_e;

  // Returns {err, value}.
  function automatic logic [4:0] decode_seg(input logic [6:0] seg);
    logic [4:0] r;
    case (seg)
      7'b1111110: r = {1'b0, 4'h0};
      7'b0110000: r = {1'b0, 4'h1};
      7'b1101101: r = {1'b0, 4'h2};
      7'b1111001: r = {1'b0, 4'h3};
      7'b0110011: r = {1'b0, 4'h4};
      7'b1011011: r = {1'b0, 4'h5};
      7'b1011111: r = {1'b0, 4'h6};
      7'b1110000: r = {1'b0, 4'h7};
      7'b1111111: r = {1'b0, 4'h8};
      7'b1111011: r = {1'b0, 4'h9};
      7'b0000001: r = {1'b0, 4'hA};
`ifdef SEG7_BLANK_EN
      7'b0000000: r = {1'b0, 4'hB};
`endif
      default:    r = {1'b1, 4'hF};
    endcase
    return r;
  endfunction

  // Stability tracking
  logic [6:0]  prev_seg_q;
  logic [3:0]  prev_sel_q;
  logic [3:0]  cnt_q, cnt_d;
  logic        done_q, done_d;

  // Working frame
  logic [3:0]  mask_q, mask_d;
  logic [15:0] work_val_q, work_val_d;
  logic [3:0]  work_err_q, work_err_d;

  // Presented frame
  state_e      state_q, state_d;
  logic [15:0] bcd_q, bcd_d;
  logic [3:0]  err_q, err_d;
  logic        valid_q, valid_d;
  logic        overrun_q, overrun_d;

  logic        same;
  logic        one_hot;
  logic [3:0]  run;
  logic        capture;
  logic [3:0]  cap_bit;
  logic [4:0]  dec;
  logic [3:0]  mask_full;
  logic        frame_done;
  logic        load;
  logic        set_ovr;

  // Capture path: dwell counting, decode and working-frame update.
  always_comb begin
    same    = (segment == prev_seg_q) && (digit_sel == prev_sel_q);
    one_hot = $onehot(digit_sel);

    // run is the length of the current dwell including this cycle. It
    // saturates at STABLE_W, so capture lands on the STABLE_CNT-th cycle.
    if (!same) begin
      run = 4'd1;
    end else if (cnt_q >= STABLE_W) begin
      run = STABLE_W;
    end else begin
      run = cnt_q + 4'd1;
    end

    // done_q blocks a second capture within the same unbroken dwell.
    capture = one_hot && (run == STABLE_W) && !(same && done_q);
    cap_bit = capture ? digit_sel : 4'b0000;
    cnt_d   = one_hot ? run : 4'd0;
    done_d  = capture | (same & done_q);

    dec        = decode_seg(segment);
    work_val_d = work_val_q;
    work_err_d = work_err_q;
    for (int i = 0; i < 4; i++) begin
      if (cap_bit[i]) begin
        work_val_d[4*i +: 4] = dec[3:0];
        work_err_d[i]        = dec[4];
      end
    end

    mask_full  = mask_q | cap_bit;
    frame_done = &mask_full;
    mask_d     = frame_done ? 4'b0000 : mask_full;
  end

  // Frame FSM: next state and output-register loads.
  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    set_ovr = 1'b0;
    case (state_q)
      ST_COLLECT: begin
        if (frame_done) begin
          load    = 1'b1;
          state_d = ST_PRESENT;
        end
      end
      ST_PRESENT: begin
        if (frame_done) begin
          // A same-cycle handshake frees the output registers for the
          // new frame. Otherwise the new frame is dropped.
          if (ready) begin
            load = 1'b1;
          end else begin
            set_ovr = 1'b1;
          end
        end else if (ready) begin
          state_d = ST_COLLECT;
        end
      end
      default: state_d = ST_COLLECT;
    endcase

    bcd_d     = load ? work_val_d : bcd_q;
    err_d     = load ? work_err_d : err_q;
    valid_d   = (state_d == ST_PRESENT);
    overrun_d = overrun_q | set_ovr;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prev_seg_q <= 7'd0;
      prev_sel_q <= 4'd0;
      cnt_q      <= 4'd0;
      done_q     <= 1'b0;
      mask_q     <= 4'd0;
      work_val_q <= 16'h0000;
      work_err_q <= 4'h0;
      state_q    <= ST_COLLECT;
      bcd_q      <= 16'h0000;
      err_q      <= 4'h0;
      valid_q    <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      prev_seg_q <= segment;
      prev_sel_q <= digit_sel;
      cnt_q      <= cnt_d;
      done_q     <= done_d;
      mask_q     <= mask_d;
      work_val_q <= work_val_d;
      work_err_q <= work_err_d;
      state_q    <= state_d;
      bcd_q      <= bcd_d;
      err_q      <= err_d;
      valid_q    <= valid_d;
      overrun_q  <= overrun_d;
    end
  end

  assign bcd_out     = bcd_q;
  assign digit_err   = err_q;
  assign valid       = valid_q;
  assign overrun     = overrun_q;
  assign dbg_state_o = state_q;

endmodule

// File: doc/seg7_scan_decoder.md
SEG7_SCAN_DECODER -- requirements
Module: seg7_scan_decoder

Interface
REQ-001 SHALL have parameter STABLE_CNT, default 4: consecutive identical cycles a segment pattern must hold before it is captured (range 1..15).
REQ-002 SHALL have port clk, input, 1: the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst, input, 1: reset; synchronous and active-high.
REQ-004 SHALL have port segment, input, 7: segment lines a..g, bit6=a ... bit0=g, 1=lit.
REQ-005 SHALL have port digit_sel, input, 4: scanned digit strobe, one-hot, active-high; bit0 = digit 0.
REQ-006 SHALL have port ready, input, 1: consumer accepts the frame when ready=1 and valid=1.
REQ-007 SHALL have port bcd_out, output, 16: four decoded digits; [3:0] = digit 0 ... [15:12] = digit 3.
REQ-008 SHALL have port digit_err, output, 4: per-digit flag, 1 = pattern not recognised.
REQ-009 SHALL have port valid, output, 1: a complete frame is presented.
REQ-010 SHALL have port overrun, output, 1: sticky; a frame was lost.

Function
REQ-011 SHALL decode patterns: 1111110->0, 0110000->1, 1101101->2, 1111001->3, 0110011->4, 1011011->5, 1011111->6, 1110000->7, 1111111->8, 1111011->9, 0000001->4'hA (dash), each with err=0.
REQ-012 SHALL decode any other pattern to 4'hF with err=1. Pattern 0000000 is covered by REQ-037.
REQ-013 SHALL treat a digit_sel value that is not one-hot as no selection: the stability counter clears and no capture occurs.
REQ-014 SHALL clear the stability counter in any cycle where segment or digit_sel differs from the previous cycle.
REQ-015 SHALL capture the selected digit into the working registers when the counter reaches STABLE_CNT, so capture occurs in the STABLE_CNT-th consecutive identical cycle.
REQ-016 SHALL capture at most once per dwell; re-arming requires a change in digit_sel or segment.
REQ-017 SHALL keep a 4-bit seen mask of captured digits; a recapture of a digit overwrites its working value and does not double-count it.
REQ-018 SHALL implement FSM COLLECT -> PRESENT. COLLECT->PRESENT when the mask becomes 1111: working registers are copied to the output registers, valid=1 in the next cycle, and the mask clears.
REQ-019 SHALL, in PRESENT, hold bcd_out, digit_err and valid stable until ready=1. A handshake returns the FSM to COLLECT, with valid=0 from the next cycle.
REQ-020 SHALL continue capturing into the working registers and mask while in PRESENT.
REQ-021 SHALL, when the mask completes in PRESENT without a same-cycle handshake, set overrun, discard that frame, clear the mask, and leave the outputs unchanged.
REQ-022 SHALL, when the mask completes in the same cycle as a handshake, load the new frame and keep valid=1 (back-to-back), with no overrun.
REQ-023 SHALL keep overrun=1 until rst.
REQ-024 SHALL have zero combinational paths from inputs to outputs; all outputs are registered.

Reset
REQ-025 SHALL, on rst=1 at a clock edge, set bcd_out=16'h0000, digit_err=4'h0, valid=0, overrun=0, FSM=COLLECT, mask=0 and counter=0.
REQ-026 SHALL give rst priority over every other event, including a handshake or capture in the same cycle.
REQ-027 SHALL discard any partially collected frame on reset mid-frame; after reset, all four digits must be captured anew.

Configuration
REQ-028 SHALL compile with macro SEG7_BLANK_EN. When defined, pattern 0000000 decodes to 4'hB with err=0 (blanked digit).
REQ-029 SHALL, when SEG7_BLANK_EN is undefined, decode 0000000 as 4'hF with err=1.

Verification
REQ-030 SHALL test: scan digits 0..3 with patterns for 1,2,3,4, each held 4 cycles, ready=1 -> bcd_out=16'h4321, digit_err=0, valid=1 for one cycle.
REQ-031 SHALL test: digit 2 held only 3 cycles, then digit_sel changes -> digit 2 not captured, valid stays 0 until a 4-cycle dwell on digit 2.
REQ-032 SHALL test: frame with digit 1 = 1000000 -> bcd_out[7:4]=4'hF, digit_err=4'b0010.
REQ-033 SHALL test: ready=0 while two full frames are scanned -> first frame held, overrun=1, and after ready=1 the first frame is consumed.
REQ-034 SHALL test: rst pulsed after 3 digits are captured -> all outputs zero, and the next valid requires all 4 digits.
REQ-035 SHALL test: digit_sel=4'b0011 held 10 cycles -> no capture; blank pattern -> 4'hB/err=0 with SEG7_BLANK_EN, 4'hF/err=1 without.

Note: REQ-036 is intentionally unused.
REQ-037 SHALL decode pattern 0000000 per REQ-028/REQ-029.
